fifo_async_core: RTL and testbench

Single-clock, parameterised first-in/first-out buffer for partial-sum words (`sum_bw` bits) between producer and consumer stages of the accelerator datapath. It accepts a word per clock when written and not full, and returns words in arrival order when read and not empty. It also reports empty/full status. Storage is a register array of 2^`ptr_len` entries addressed by wrap-around pointers.

---
 rtl/fifo_async_core_pkg.sv | 11 +
 rtl/fifo_async_core_ptr.sv | 31 +++
 rtl/fifo_async_core.sv | 77 +++++++
 tb/tb_fifo_async_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_async_core_pkg.sv
// Shared constants for the partial-sum FIFO: default word/pointer widths and depth helper.
package fifo_async_core_pkg;

    localparam int unsigned PSUM_BW      = 22;
    localparam int unsigned FIFO_PTR_LEN = 4;

    function automatic int unsigned fifo_depth(input int unsigned ptr_len);
        return 32'd1 << ptr_len;
    endfunction

endpackage

// File: rtl/fifo_async_core_ptr.sv
// Wrap-flagged FIFO pointer: ptr_len address bits plus an MSB wrap flag, advanced on en.
module fifo_ptr #(
    parameter int unsigned ptr_len = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic [ptr_len:0] ptr
);

    logic [ptr_len:0] ptr_d;
    logic [ptr_len:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = ptr_q + (ptr_len + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_async_core.sv
// Single-clock partial-sum FIFO: register-array storage, wrap-flag pointers, registered read port.
module fifo_async_core
    import fifo_async_core_pkg::*;
#(
    parameter int unsigned sum_bw  = PSUM_BW,
    parameter int unsigned ptr_len = FIFO_PTR_LEN
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr,
    input  logic              rd,
    input  logic [sum_bw-1:0] in,
    input  logic              direction,
    output logic [sum_bw-1:0] out,
    output logic              fifo_empty,
    output logic              fifo_full
);

    localparam int unsigned DEPTH = fifo_depth(ptr_len);

    logic [ptr_len:0]  wr_ptr;
    logic [ptr_len:0]  rd_ptr;
    logic              wr_en;
    logic              rd_en;
    logic [sum_bw-1:0] mem_q [DEPTH];
    logic [sum_bw-1:0] out_d;
    logic [sum_bw-1:0] out_q;
    logic              unused_direction;

    // Reserved mode input, kept on the port list only for drop-in compatibility.
    assign unused_direction = direction;

    fifo_ptr #(.ptr_len(ptr_len)) u_wr_ptr (
        .clk  (clk),
        .rstn (rstn),
        .en   (wr_en),
        .ptr  (wr_ptr)
    );

    fifo_ptr #(.ptr_len(ptr_len)) u_rd_ptr (
        .clk  (clk),
        .rstn (rstn),
        .en   (rd_en),
        .ptr  (rd_ptr)
    );

    // Each side is qualified only by its own flag, so at full only the read
    // proceeds and at empty only the write does.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[ptr_len-1:0] == rd_ptr[ptr_len-1:0]) &&
                     (wr_ptr[ptr_len] != rd_ptr[ptr_len]);
        wr_en      = wr && !fifo_full;
        rd_en      = rd && !fifo_empty;
        out_d      = out_q;
        if (rd_en) begin
            out_d = mem_q[rd_ptr[ptr_len-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr[ptr_len-1:0]] <= in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_fifo_async_core.sv
// Bench for fifo_async_core: directed vector table plus queue-model scoreboard sequences.
module tb_fifo_async_core;

    localparam int unsigned SW    = 22;
    localparam int unsigned PL    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          rstn;
    logic          wr;
    logic          rd;
    logic [SW-1:0] din;
    logic          direction;
    logic [SW-1:0] dout;
    logic          fifo_empty;
    logic          fifo_full;

    int unsigned n_tests;
    int unsigned n_failed;

    logic [SW-1:0] model_q[$];
    logic [SW-1:0] exp_out;

    typedef struct {
        logic          w;
        logic          r;
        logic [SW-1:0] d;
        logic [SW-1:0] e_out;
        logic          e_empty;
        logic          e_full;
    } vec_t;

    vec_t tbl[9];

    fifo_async_core #(.sum_bw(SW), .ptr_len(PL)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr         (wr),
        .rd         (rd),
        .in         (din),
        .direction  (direction),
        .out        (dout),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic [SW-1:0] d, input bit chk);
        bit acc_w;
        bit acc_r;
        @(negedge clk);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        acc_r = r && (model_q.size() != 0);
        acc_w = w && (model_q.size() != DEPTH);
        if (acc_r) exp_out = model_q.pop_front();
        if (acc_w) model_q.push_back(d);
        #1;
        if (chk) begin
            check("out", 32'(dout), 32'(exp_out));
            check("fifo_empty", 32'(fifo_empty), 32'(model_q.size() == 0));
            check("fifo_full", 32'(fifo_full), 32'(model_q.size() == DEPTH));
        end
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_failed  = 0;
        exp_out   = '0;
        rstn      = 1'b0;
        wr        = 1'b0;
        rd        = 1'b0;
        din       = '0;
        direction = 1'b0;

        // Directed vectors from reset: read-on-empty, basic order, simultaneous at empty.
        tbl[0] = '{w:1'b0, r:1'b1, d:22'd0, e_out:22'd0, e_empty:1'b1, e_full:1'b0};
        tbl[1] = '{w:1'b1, r:1'b0, d:22'd5, e_out:22'd0, e_empty:1'b0, e_full:1'b0};
        tbl[2] = '{w:1'b1, r:1'b0, d:22'd6, e_out:22'd0, e_empty:1'b0, e_full:1'b0};
        tbl[3] = '{w:1'b0, r:1'b1, d:22'd0, e_out:22'd5, e_empty:1'b0, e_full:1'b0};
        tbl[4] = '{w:1'b1, r:1'b1, d:22'd7, e_out:22'd6, e_empty:1'b0, e_full:1'b0};
        tbl[5] = '{w:1'b0, r:1'b1, d:22'd0, e_out:22'd7, e_empty:1'b1, e_full:1'b0};
        tbl[6] = '{w:1'b0, r:1'b1, d:22'd0, e_out:22'd7, e_empty:1'b1, e_full:1'b0};
        tbl[7] = '{w:1'b1, r:1'b1, d:22'd9, e_out:22'd7, e_empty:1'b0, e_full:1'b0};
        tbl[8] = '{w:1'b0, r:1'b1, d:22'd0, e_out:22'd9, e_empty:1'b1, e_full:1'b0};

        // Reset held 10 cycles with rd pulses.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("reset_empty", 32'(fifo_empty), 32'd1);
            check("reset_full", 32'(fifo_full), 32'd0);
            check("reset_out", 32'(dout), 32'd0);
        end
        @(negedge clk);
        rd   = 1'b0;
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d, 1'b0);
            check($sformatf("vec%0d_out", i), 32'(dout), 32'(tbl[i].e_out));
            check($sformatf("vec%0d_empty", i), 32'(fifo_empty), 32'(tbl[i].e_empty));
            check($sformatf("vec%0d_full", i), 32'(fifo_full), 32'(tbl[i].e_full));
        end

        // Overfill: 30 writes every other cycle, 17..30 dropped.
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b0, SW'(i), 1'b1);
            if (i == 16) check("full_after_16", 32'(fifo_full), 32'd1);
        end

        // Drain past empty: out 1..16 then holds 16.
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b1, '0, 1'b1);
            check("drain_out", 32'(dout), (i <= 16) ? 32'(i) : 32'd16);
        end

        // Simultaneous rd/wr at occupancy 5 for 20 cycles.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, SW'(100 + i), 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, SW'(200 + i), 1'b1);
            check("occ5_out", 32'(dout), (i < 5) ? 32'(100 + i) : 32'(200 + i - 5));
        end
        check("occ5_size", 32'(model_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, 1'b1);

        // Simultaneous at full: only the read happens.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, SW'(300 + i), 1'b1);
        step(1'b1, 1'b1, SW'(999), 1'b1);
        check("full_rdwr_out", 32'(dout), 32'd300);
        check("full_rdwr_notfull", 32'(fifo_full), 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0, 1'b1);
        check("full_rdwr_last", 32'(dout), 32'd315);

        // Simultaneous at empty: only the write happens.
        step(1'b1, 1'b1, SW'(777), 1'b1);
        check("empty_rdwr_out", 32'(dout), 32'd315);
        step(1'b0, 1'b1, '0, 1'b1);
        check("empty_rdwr_read", 32'(dout), 32'd777);

        // Wrap-around: 40 streamed words at low occupancy.
        step(1'b1, 1'b0, SW'($urandom), 1'b1);
        step(1'b1, 1'b0, SW'($urandom), 1'b1);
        for (int i = 0; i < 38; i++) step(1'b1, 1'b1, SW'($urandom), 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        check("wrap_empty", 32'(fifo_empty), 32'd1);

        // Mid-operation asynchronous reset at occupancy 7.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, SW'(500 + i), 1'b1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        model_q.delete();
        exp_out = '0;
        check("midrst_empty", 32'(fifo_empty), 32'd1);
        check("midrst_full", 32'(fifo_full), 32'd0);
        check("midrst_out", 32'(dout), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, 1'b0, SW'(4242), 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        check("midrst_newval", 32'(dout), 32'd4242);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
